reg_file_sb: RTL and testbench



---
 rtl/reg_file_sb_if.sv | 44 ++++
 rtl/reg_file_sb.sv | 132 +++++++++++++
 tb/tb_reg_file_sb.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Register-file bus: read ports, general/link/hilo writes, issue marking
// and status outputs.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_id;
  logic [NUM_RD*DATA_W-1:0] rd_value;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_id;
  logic [DATA_W-1:0]        wr_value;
  logic                     ra_write;
  logic [DATA_W-1:0]        ra_write_value;
  logic                     hilo_write;
  logic [DATA_W-1:0]        hi_in;
  logic [DATA_W-1:0]        lo_in;
  logic [DATA_W-1:0]        hi_out;
  logic [DATA_W-1:0]        lo_out;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_id;
  logic [DATA_W-1:0]        syscall_funct;
  logic [DATA_W-1:0]        syscall_param1;
  logic                     ready;

  modport master (
    output rd_id, wr_en, wr_id, wr_value,
    output ra_write, ra_write_value,
    output hilo_write, hi_in, lo_in,
    output issue_en, issue_id,
    input  rd_value, rd_busy, hi_out, lo_out,
    input  syscall_funct, syscall_param1, ready
  );

  modport slave (
    input  rd_id, wr_en, wr_id, wr_value,
    input  ra_write, ra_write_value,
    input  hilo_write, hi_in, lo_in,
    input  issue_en, issue_id,
    output rd_value, rd_busy, hi_out, lo_out,
    output syscall_funct, syscall_param1, ready
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with zeroing sweep, write bypass, busy scoreboard
// and hi/lo pair.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int RA_ID  = 31,
  parameter int V0_ID  = 2,
  parameter int A0_ID  = 4
) (
  input  logic         clock,
  input  logic         reset,
  reg_file_sb_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_W-1:0] RA   = ADDR_W'(RA_ID);
  localparam logic [ADDR_W-1:0] V0   = ADDR_W'(V0_ID);
  localparam logic [ADDR_W-1:0] A0   = ADDR_W'(A0_ID);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);
  localparam logic [ADDR_W-1:0] ZERO = '0;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic                     w_run;
  logic                     w_gen_we;
  logic                     w_ra_we;
  logic                     w_issue;
  logic [NREG-1:0]          w_busy_nxt;
  logic [NUM_RD*DATA_W-1:0] w_rd_value;
  logic [NUM_RD-1:0]        w_rd_busy;

  assign w_run    = r_state == ST_RUN;
  assign w_gen_we = w_run && bus.wr_en && bus.wr_id != ZERO;
  assign w_ra_we  = w_run && bus.ra_write && RA != ZERO;
  assign w_issue  = w_run && bus.issue_en && bus.issue_id != ZERO;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      unique case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Link write is applied last so it wins a same-id collision.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (!w_run) begin
        r_regs[r_cnt] <= '0;
      end else begin
        if (w_gen_we) r_regs[bus.wr_id] <= bus.wr_value;
        if (w_ra_we)  r_regs[RA] <= bus.ra_write_value;
      end
    end
  end

  // Issue is applied after the clears so a new producer stays pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_gen_we) w_busy_nxt[bus.wr_id] = 1'b0;
    if (w_ra_we)  w_busy_nxt[RA] = 1'b0;
    if (w_issue)  w_busy_nxt[bus.issue_id] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_run && bus.hilo_write) begin
        r_hi <= bus.hi_in;
        r_lo <= bus.lo_in;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_id;
    logic              w_hit_ra;
    logic              w_hit_wr;
    logic [DATA_W-1:0] w_val;

    assign w_id     = bus.rd_id[k*ADDR_W +: ADDR_W];
    assign w_hit_ra = w_ra_we && w_id == RA;
    assign w_hit_wr = w_gen_we && w_id == bus.wr_id;

    assign w_val = (!w_run || w_id == ZERO) ? '0 :
                   w_hit_ra ? bus.ra_write_value :
                   w_hit_wr ? bus.wr_value :
                   r_regs[w_id];

    assign w_rd_value[k*DATA_W +: DATA_W] = w_val;
    assign w_rd_busy[k] = w_run && r_busy[w_id]
                        && !(w_hit_ra || w_hit_wr);
  end

  assign bus.rd_value       = w_rd_value;
  assign bus.rd_busy        = w_rd_busy;
  assign bus.hi_out         = r_hi;
  assign bus.lo_out         = r_lo;
  assign bus.ready          = r_ready;
  assign bus.syscall_funct  = w_run ? r_regs[V0] : '0;
  assign bus.syscall_param1 = w_run ? r_regs[A0] : '0;
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench: default instance plus a small 8x16 four-port instance,
// both driven in lockstep and checked against an array model.
module tb_reg_file_sb;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [127:0] rv;
    logic [3:0]   rb;
    logic         rdy;
    logic [31:0]  hi;
    logic [31:0]  lo;
    logic [31:0]  sf;
    logic [31:0]  sp;
    logic         chk_sys;
  } exp_t;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) b0 ();
  reg_file_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) b1 ();

  logic        s_rst  [2];
  logic [4:0]  s_rdid [2][4];
  logic        s_we   [2];
  logic [4:0]  s_wid  [2];
  logic [31:0] s_wv   [2];
  logic        s_raw  [2];
  logic [31:0] s_rav  [2];
  logic        s_hw   [2];
  logic [31:0] s_hi   [2];
  logic [31:0] s_lo   [2];
  logic        s_ie   [2];
  logic [4:0]  s_iid  [2];

  logic rst0, rst1;
  assign rst0 = s_rst[0];
  assign rst1 = s_rst[1];

  reg_file_sb #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2),
    .RA_ID(31), .V0_ID(2), .A0_ID(4)
  ) u0 (.clock(clock), .reset(rst0), .bus(b0));

  reg_file_sb #(
    .DATA_W(16), .ADDR_W(3), .NUM_RD(4),
    .RA_ID(7), .V0_ID(2), .A0_ID(4)
  ) u1 (.clock(clock), .reset(rst1), .bus(b1));

  always_comb begin
    b0.rd_id          = {s_rdid[0][1], s_rdid[0][0]};
    b0.wr_en          = s_we[0];
    b0.wr_id          = s_wid[0];
    b0.wr_value       = s_wv[0];
    b0.ra_write       = s_raw[0];
    b0.ra_write_value = s_rav[0];
    b0.hilo_write     = s_hw[0];
    b0.hi_in          = s_hi[0];
    b0.lo_in          = s_lo[0];
    b0.issue_en       = s_ie[0];
    b0.issue_id       = s_iid[0];
    b1.rd_id          = {s_rdid[1][3][2:0], s_rdid[1][2][2:0],
                         s_rdid[1][1][2:0], s_rdid[1][0][2:0]};
    b1.wr_en          = s_we[1];
    b1.wr_id          = s_wid[1][2:0];
    b1.wr_value       = s_wv[1][15:0];
    b1.ra_write       = s_raw[1];
    b1.ra_write_value = s_rav[1][15:0];
    b1.hilo_write     = s_hw[1];
    b1.hi_in          = s_hi[1][15:0];
    b1.lo_in          = s_lo[1][15:0];
    b1.issue_en       = s_ie[1];
    b1.issue_id       = s_iid[1][2:0];
  end

  logic [127:0] o_rv  [2];
  logic [3:0]   o_rb  [2];
  logic         o_rdy [2];
  logic [31:0]  o_hi  [2];
  logic [31:0]  o_lo  [2];
  logic [31:0]  o_sf  [2];
  logic [31:0]  o_sp  [2];

  always_comb begin
    o_rv[0]  = {64'b0, b0.rd_value};
    o_rb[0]  = {2'b0, b0.rd_busy};
    o_rdy[0] = b0.ready;
    o_hi[0]  = b0.hi_out;
    o_lo[0]  = b0.lo_out;
    o_sf[0]  = b0.syscall_funct;
    o_sp[0]  = b0.syscall_param1;
    o_rv[1]  = '0;
    for (int k = 0; k < 4; k++)
      o_rv[1][k*32 +: 32] = {16'b0, b1.rd_value[k*16 +: 16]};
    o_rb[1]  = b1.rd_busy;
    o_rdy[1] = b1.ready;
    o_hi[1]  = {16'b0, b1.hi_out};
    o_lo[1]  = {16'b0, b1.lo_out};
    o_sf[1]  = {16'b0, b1.syscall_funct};
    o_sp[1]  = {16'b0, b1.syscall_param1};
  end

  function automatic int nreg(int i); return i == 0 ? 32 : 8; endfunction
  function automatic int nrd(int i);  return i == 0 ? 2 : 4;  endfunction
  function automatic int ra(int i);   return i == 0 ? 31 : 7; endfunction
  function automatic logic [31:0] msk(int i);
    return i == 0 ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // Reference state: register values, pending flags, hi/lo, and the
  // number of clean cycles since the last reset (ready once >= depth).
  logic [31:0] m_reg  [2][32];
  bit          m_busy [2][32];
  logic [31:0] m_hi   [2];
  logic [31:0] m_lo   [2];
  int          m_since[2];

  function automatic bit m_run(int i);
    return m_since[i] >= nreg(i);
  endfunction

  function automatic bit hit_ra(int i, int id);
    return m_run(i) && s_raw[i] && id == ra(i);
  endfunction

  function automatic bit hit_wr(int i, int id);
    return m_run(i) && s_we[i] && id != 0 && id == int'(s_wid[i]);
  endfunction

  function automatic exp_t expect_of(int i);
    exp_t e;
    int id;
    e = '0;
    e.rdy     = m_run(i);
    e.hi      = m_hi[i];
    e.lo      = m_lo[i];
    e.chk_sys = m_run(i);
    e.sf      = m_reg[i][2];
    e.sp      = m_reg[i][4];
    if (m_run(i)) begin
      for (int k = 0; k < nrd(i); k++) begin
        id = int'(s_rdid[i][k]);
        if (id != 0) begin
          if (hit_ra(i, id))      e.rv[k*32 +: 32] = s_rav[i];
          else if (hit_wr(i, id)) e.rv[k*32 +: 32] = s_wv[i];
          else                    e.rv[k*32 +: 32] = m_reg[i][id];
          e.rb[k] = m_busy[i][id] && !hit_ra(i, id) && !hit_wr(i, id);
        end
      end
    end
    return e;
  endfunction

  task automatic m_update(int i);
    if (s_rst[i]) begin
      m_since[i] = 0;
      m_hi[i] = '0;
      m_lo[i] = '0;
      for (int r = 0; r < 32; r++) begin
        m_reg[i][r]  = '0;
        m_busy[i][r] = 1'b0;
      end
    end else if (!m_run(i)) begin
      m_since[i]++;
    end else begin
      if (s_we[i] && s_wid[i] != 0) begin
        m_reg[i][s_wid[i]]  = s_wv[i];
        m_busy[i][s_wid[i]] = 1'b0;
      end
      if (s_raw[i]) begin
        m_reg[i][ra(i)]  = s_rav[i];
        m_busy[i][ra(i)] = 1'b0;
      end
      if (s_ie[i] && s_iid[i] != 0) m_busy[i][s_iid[i]] = 1'b1;
      if (s_hw[i]) begin
        m_hi[i] = s_hi[i];
        m_lo[i] = s_lo[i];
      end
    end
  endtask

  exp_t q0[$];
  exp_t q1[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic cmp(int i, string nm, logic [127:0] got, logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL inst%0d t=%0t %s: got %h want %h", i, $time, nm, got, want);
    end
  endtask

  task automatic check(int i, exp_t e);
    cmp(i, "rd_value", o_rv[i], e.rv);
    cmp(i, "rd_busy", {124'b0, o_rb[i]}, {124'b0, e.rb});
    cmp(i, "ready", {127'b0, o_rdy[i]}, {127'b0, e.rdy});
    cmp(i, "hi_out", {96'b0, o_hi[i]}, {96'b0, e.hi});
    cmp(i, "lo_out", {96'b0, o_lo[i]}, {96'b0, e.lo});
    if (e.chk_sys) begin
      cmp(i, "syscall_funct", {96'b0, o_sf[i]}, {96'b0, e.sf});
      cmp(i, "syscall_param1", {96'b0, o_sp[i]}, {96'b0, e.sp});
    end
  endtask

  always @(negedge clock) begin
    if (q0.size() > 0) check(0, q0.pop_front());
    if (q1.size() > 0) check(1, q1.pop_front());
  end

  task automatic step();
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
    @(posedge clock);
    m_update(0);
    m_update(1);
    #1;
  endtask

  task automatic idle(int i);
    for (int k = 0; k < 4; k++) s_rdid[i][k] = '0;
    s_we[i]  = 1'b0; s_wid[i] = '0; s_wv[i] = '0;
    s_raw[i] = 1'b0; s_rav[i] = '0;
    s_hw[i]  = 1'b0; s_hi[i]  = '0; s_lo[i] = '0;
    s_ie[i]  = 1'b0; s_iid[i] = '0;
  endtask

  function automatic logic [4:0] pick(int i);
    int c;
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, nreg(i) - 1));
    c = $urandom_range(0, 3);
    if (c == 0) return 5'd0;
    if (c == 1) return 5'd2;
    if (c == 2) return 5'd4;
    return 5'(ra(i));
  endfunction

  task automatic rand_in(int i);
    for (int k = 0; k < 4; k++) s_rdid[i][k] = pick(i);
    s_we[i]  = 1'($urandom_range(0, 1));
    s_wid[i] = pick(i);
    s_wv[i]  = $urandom & msk(i);
    s_raw[i] = ($urandom_range(0, 3) == 0);
    s_rav[i] = $urandom & msk(i);
    s_hw[i]  = ($urandom_range(0, 7) == 0);
    s_hi[i]  = $urandom & msk(i);
    s_lo[i]  = $urandom & msk(i);
    s_ie[i]  = ($urandom_range(0, 2) == 0);
    s_iid[i] = pick(i);
    s_rst[i] = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      idle(i);
      s_rst[i] = 1'b1;
    end
    @(posedge clock);
    m_update(0);
    m_update(1);
    #1;
    s_rst[0] = 1'b0;
    s_rst[1] = 1'b0;

    repeat (34) step();
    for (int r = 0; r < 32; r += 2) begin
      s_rdid[0][0] = 5'(r);
      s_rdid[0][1] = 5'(r + 1);
      step();
    end

    s_we[0] = 1'b1; s_wid[0] = 5'd5; s_wv[0] = 32'hDEAD_BEEF;
    s_rdid[0][0] = 5'd5;
    step();
    s_we[0] = 1'b0;
    step();

    s_we[0] = 1'b1; s_wid[0] = 5'd31; s_wv[0] = 32'h11;
    s_raw[0] = 1'b1; s_rav[0] = 32'h22;
    s_rdid[0][0] = 5'd31;
    step();
    s_we[0] = 1'b0; s_raw[0] = 1'b0;
    step();
    s_we[0] = 1'b1; s_wid[0] = 5'd0; s_wv[0] = 32'h55;
    s_rdid[0][0] = 5'd0;
    step();
    s_we[0] = 1'b0;
    step();

    s_ie[0] = 1'b1; s_iid[0] = 5'd7; s_rdid[0][0] = 5'd7;
    step();
    s_ie[0] = 1'b0;
    step();
    s_we[0] = 1'b1; s_wid[0] = 5'd7; s_wv[0] = 32'h77;
    step();
    s_we[0] = 1'b0;
    step();
    s_ie[0] = 1'b1; s_we[0] = 1'b1; s_wv[0] = 32'h78;
    step();
    s_ie[0] = 1'b0; s_we[0] = 1'b0;
    step();

    s_hw[0] = 1'b1; s_hi[0] = 32'hA; s_lo[0] = 32'hB;
    step();
    s_hw[0] = 1'b0;
    step();

    s_we[0] = 1'b1; s_wid[0] = 5'd2; s_wv[0] = 32'h10;
    step();
    s_wid[0] = 5'd4; s_wv[0] = 32'h20;
    step();
    s_we[0] = 1'b0;
    step();

    s_we[1] = 1'b1; s_wid[1] = 5'd3; s_wv[1] = 32'h1234;
    s_raw[1] = 1'b1; s_rav[1] = 32'hBEEF;
    s_rdid[1][0] = 5'd3; s_rdid[1][1] = 5'd5;
    s_rdid[1][2] = 5'd7; s_rdid[1][3] = 5'd0;
    step();
    idle(1);
    s_rdid[1][0] = 5'd7; s_rdid[1][1] = 5'd3;
    step();

    s_rst[0] = 1'b1;
    step();
    s_rst[0] = 1'b0;
    repeat (10) step();
    s_rst[0] = 1'b1;
    step();
    s_rst[0] = 1'b0;
    idle(0);
    s_rdid[0][0] = 5'd5;
    repeat (34) step();

    repeat (3000) begin
      rand_in(0);
      rand_in(1);
      step();
    end

    s_rst[0] = 1'b0;
    s_rst[1] = 1'b0;
    idle(0);
    idle(1);
    repeat (2) @(negedge clock);
    #1;
    n_chk++;
    if (q0.size() + q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q0.size() + q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
